// File: rtl/shift_pipe.sv
// shift_pipe: pipelined logarithmic barrel shifter with valid/ready on both sides.
// Supports SLL, SRL and SRA. Rotate-right is built only when SHIFT_PIPE_ROTATE_EN
// is defined; otherwise op 11 is executed as SRL and still reported as 11.
// Stage k shifts by 2^(STAGES-1-k), so the largest shift happens first, and every
// stage is registered. The whole pipe advances together or stalls together.
module shift_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op
);

  localparam int STAGES = SHW;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage registers and their next-state values
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [SHW-1:0]    shamt_q [STAGES];
  logic [SHW-1:0]    shamt_d [STAGES];
  logic [1:0]        op_q    [STAGES];
  logic [1:0]        op_d    [STAGES];
  logic              fill_q  [STAGES];
  logic              fill_d  [STAGES];

  // Inputs seen by each stage: the port for stage 0, the previous register otherwise
  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_data  [STAGES];
  logic [SHW-1:0]    src_shamt [STAGES];
  logic [1:0]        src_op    [STAGES];
  logic              src_fill  [STAGES];

  logic advance;

  // One fixed-distance shift step; fill only ever lands in the vacated MSBs.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       op,
    input logic             fill,
    input int               sh
  );
    logic [WIDTH-1:0] fill_hi;
    logic [WIDTH-1:0] r;
    fill_hi = fill ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (op)
      OP_SLL: r = x << sh;
`ifdef SHIFT_PIPE_ROTATE_EN
      OP_ROR: r = (x >> sh) | (x << (WIDTH - sh));
`else
      OP_ROR: r = x >> sh;
`endif
      default: r = (x >> sh) | fill_hi;
    endcase
    return r;
  endfunction

  // Global advance: the pipe moves whenever the final slot is empty or being drained
  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];

  // Route each stage's source and compute its conditionally shifted next value
  always_comb begin
    src_vld      = '0;
    src_vld[0]   = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_fill[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]   = vld_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_fill[k]  = fill_q[k-1];
    end
    vld_d = src_vld;
    for (int k = 0; k < STAGES; k++) begin
      shamt_d[k] = src_shamt[k];
      op_d[k]    = src_op[k];
      fill_d[k]  = src_fill[k];
      data_d[k]  = src_data[k];
      if (src_shamt[k][STAGES-1-k]) begin
        data_d[k] = stage_shift(src_data[k], src_op[k], src_fill[k], 1 << (STAGES-1-k));
      end
    end
  end

  // Stage register bank: reset flushes every slot, otherwise all stages move on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q            <= '0;
      data_q[STAGES-1] <= '0;
      op_q[STAGES-1]   <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        fill_q[k]  <= fill_d[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and randomized checks of shift_pipe (WIDTH = 32)
// against a transaction-level model: a queue of expected results, each
// carrying how many pipeline advances it has seen since acceptance.
module tb_shift_pipe;

  localparam int W = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data;
  logic [4:0]   in_shamt;
  logic [1:0]   in_op;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_op;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   op;
    int           prog;
  } ent_t;

  ent_t         sb[$];
  logic [W-1:0] ret_log[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_acc = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic [1:0]   prev_op;

  // Result of an op, from the instruction's definition
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] d, input int sh);
    logic [2*W-1:0] dd;
    case (op)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return W'($signed(d) >>> sh);
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        dd = {d, d} >> sh;
        return dd[W-1:0];
`else
        dd = '0;
        return d >> sh;
`endif
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, update the model for the coming edge
  task automatic step(input logic iv, input logic [1:0] op, input logic [W-1:0] d,
                      input logic [4:0] sh, input logic ordy);
    logic exp_ov, exp_rdy;
    ent_t e;
    in_valid  = iv;
    in_op     = op;
    in_data   = d;
    in_shamt  = sh;
    out_ready = ordy;
    #1;
    exp_ov  = (sb.size() > 0) && (sb[0].prog >= L);
    exp_rdy = !exp_ov || ordy;
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, exp_rdy);
    if (prev_stall) begin
      check("stall_data", out_data, prev_data);
      check("stall_op", out_op, prev_op);
    end
    if (exp_ov && ordy) begin
      e = sb.pop_front();
      check("out_data", out_data, e.res);
      check("out_op", out_op, e.op);
      ret_log.push_back(out_data);
    end
    prev_stall = exp_ov && !ordy;
    prev_data  = out_data;
    prev_op    = out_op;
    if (exp_rdy) begin
      foreach (sb[i]) sb[i].prog++;
    end
    if (iv && exp_rdy) begin
      e.res  = ref_shift(op, d, int'(sh));
      e.op   = op;
      e.prog = 1;
      sb.push_back(e);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (sb.size() > 0 && c < budget) begin
      step(1'b0, 2'b00, '0, '0, 1'b1);
      c++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_stall = 0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_op", out_op, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_op = '0;
    @(negedge clk);
    do_reset();

    // Single SRA with exact latency
    ret_log.delete();
    step(1'b1, 2'b10, 32'h8000_0000, 5'd4, 1'b1);
    lat = 0;
    while (sb.size() > 0 && lat < 20) begin
      lat++;
      step(1'b0, 2'b00, '0, '0, 1'b1);
    end
    check("sra_latency", lat, L);
    check("sra_result", (ret_log.size() > 0) ? ret_log[0] : 32'hx, 32'hF800_0000);

    // Back-to-back stream
    ret_log.delete();
    step(1'b1, 2'b00, 32'h0000_0001, 5'd31, 1'b1);
    step(1'b1, 2'b01, 32'h8000_0000, 5'd31, 1'b1);
    step(1'b1, 2'b10, 32'h7FFF_FFFF, 5'd1,  1'b1);
    step(1'b1, 2'b10, 32'h8BAD_F00D, 5'd0,  1'b1);
    step(1'b1, 2'b11, 32'hCAFE_BABE, 5'd0,  1'b1);
    drain(20);
    check("stream_count", ret_log.size(), 5);
    if (ret_log.size() == 5) begin
      check("stream_sll31", ret_log[0], 32'h8000_0000);
      check("stream_srl31", ret_log[1], 32'h0000_0001);
      check("stream_sra1",  ret_log[2], 32'h3FFF_FFFF);
      check("stream_sh0_a", ret_log[3], 32'h8BAD_F00D);
      check("stream_sh0_b", ret_log[4], 32'hCAFE_BABE);
    end

    // Backpressure: fill, stall three cycles, resume
    ret_log.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i % 4), $urandom, 5'($urandom_range(0, 31)), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd3, 1'b0);
    drain(30);
    check("bp_count", ret_log.size(), 5);

    // Rotate right
    ret_log.delete();
    step(1'b1, 2'b11, 32'h1234_5678, 5'd8, 1'b1);
    drain(20);
`ifdef SHIFT_PIPE_ROTATE_EN
    check("ror8", (ret_log.size() > 0) ? ret_log[0] : 32'hx, 32'h7812_3456);
`else
    check("ror8_as_srl", (ret_log.size() > 0) ? ret_log[0] : 32'hx, 32'h0012_3456);
`endif

    // Reset with three ops in flight, then a fresh op
    step(1'b1, 2'b00, 32'h0000_00FF, 5'd4, 1'b1);
    step(1'b1, 2'b01, 32'hFF00_0000, 5'd4, 1'b1);
    step(1'b1, 2'b10, 32'h8000_0000, 5'd2, 1'b1);
    do_reset();
    ret_log.delete();
    step(1'b1, 2'b00, 32'h0000_0003, 5'd2, 1'b1);
    drain(20);
    check("post_rst_count", ret_log.size(), 1);
    check("post_rst_result", (ret_log.size() > 0) ? ret_log[0] : 32'hx, 32'h0000_000C);

    // Randomized traffic with random backpressure
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
           5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
      cyc++;
    end
    check("rand_accepted", n_acc >= 10000, 1'b1);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
